// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control unit and the multicycle mult/div unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             MultOp;
  logic             DivOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             busy;
  logic             done;
  logic             DivZero;

  modport master (output MultOp, DivOp, A, B, input HI, LO, busy, done, DivZero);
  modport slave  (input MultOp, DivOp, A, B, output HI, LO, busy, done, DivZero);
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit writing HI/LO.
// Optional macro DIVZERO_DETECT_EN: early done+DivZero on B==0 instead of a full divide.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           RESET_in,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH:0] prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             op_div_q, op_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef DIVZERO_DETECT_EN
  logic             dz_q, dz_d;
  logic             dz_pend_q, dz_pend_d;
`endif

  // Upper product half is widened by one bit so that subtracting MIN cannot overflow.
  logic [WIDTH:0] upper_ext, addend, booth_sum;
  logic [WIDTH:0] trial, diff;

  assign upper_ext = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
  assign addend    = {mcand_q[WIDTH-1], mcand_q};
  assign booth_sum = (prod_q[1:0] == 2'b01) ? upper_ext + addend :
                     (prod_q[1:0] == 2'b10) ? upper_ext - addend : upper_ext;
  assign trial     = {rem_q, quo_q[WIDTH-1]};
  assign diff      = trial - {1'b0, dvsr_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    op_div_d = op_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef DIVZERO_DETECT_EN
    dz_d      = 1'b0;
    dz_pend_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef DIVZERO_DETECT_EN
        if (dz_pend_q) begin
          done_d = 1'b1;
          dz_d   = 1'b1;
        end else
`endif
        if (bus.MultOp) begin
          mcand_d  = bus.A;
          prod_d   = {{WIDTH{1'b0}}, bus.B, 1'b0};
          cnt_d    = '0;
          op_div_d = 1'b0;
          state_d  = MULT;
        end else if (bus.DivOp) begin
`ifdef DIVZERO_DETECT_EN
          if (bus.B == '0) dz_pend_d = 1'b1;
          else
`endif
          begin
            sign_a_d = bus.A[WIDTH-1];
            sign_b_d = bus.B[WIDTH-1];
            quo_d    = bus.A[WIDTH-1] ? -bus.A : bus.A;
            dvsr_d   = bus.B[WIDTH-1] ? -bus.B : bus.B;
            rem_d    = '0;
            cnt_d    = '0;
            op_div_d = 1'b1;
            state_d  = DIV;
          end
        end
      end
      MULT: begin
        prod_d = {booth_sum, prod_q[WIDTH:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      DIV: begin
        // diff sign bit clear means the shifted remainder covers the divisor
        if (!diff[WIDTH]) begin
          rem_d = diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        if (op_div_q) begin
          lo_d = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
          hi_d = sign_a_q ? -rem_q : rem_q;
        end else begin
          hi_d = prod_q[2*WIDTH:WIDTH+1];
          lo_d = prod_q[WIDTH:1];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge RESET_in) begin
    if (RESET_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      op_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef DIVZERO_DETECT_EN
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      op_div_q  <= op_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef DIVZERO_DETECT_EN
      dz_q      <= dz_d;
      dz_pend_q <= dz_pend_d;
`endif
    end
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef DIVZERO_DETECT_EN
  assign bus.DivZero = dz_q;
`else
  assign bus.DivZero = 1'b0;
`endif
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, hand sequences, random ops vs. a 64-bit model.
module tb_mult_div_unit;
  logic clock = 1'b0;
  logic RESET_in = 1'b1;
  always #5 clock = ~clock;

  mult_div_unit_if #(.WIDTH(32)) bus();
  mult_div_unit #(.WIDTH(32)) dut (.clock(clock), .RESET_in(RESET_in), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    bit          dz;
  } exp_t;

  typedef struct {
    string       name;
    bit          m;
    bit          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ph, input logic [31:0] pl);
    exp_t        e;
    logic [63:0] w;
    longint      sa, sb;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    e.lat = 33;
    e.dz  = 1'b0;
    if (m) begin
      w    = sa * sb;
      e.hi = w[63:32];
      e.lo = w[31:0];
    end else if (b == 32'h0) begin
`ifdef DIVZERO_DETECT_EN
      e.hi  = ph;
      e.lo  = pl;
      e.lat = 1;
      e.dz  = 1'b1;
`else
      e.hi = a;
      e.lo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
`endif
    end else begin
      w    = sa / sb;
      e.lo = w[31:0];
      w    = sa % sb;
      e.hi = w[31:0];
    end
    return e;
  endfunction

  // Drives one start, optionally pokes DivOp at edge inj, waits for done and scores it.
  task automatic run_op(input string name, input bit m, input bit d, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, input int inj);
    exp_t got;
    int   k;
    bit   seen;
    sb_q.push_back(e);
    @(negedge clock);
    bus.MultOp = m; bus.DivOp = d; bus.A = a; bus.B = b;
    @(posedge clock); #1;
    bus.MultOp = 1'b0; bus.DivOp = 1'b0;
    bus.A = ~a; bus.B = b ^ 32'h5A5A_0001;
    k = 0; seen = 1'b0;
    while (!seen && k < 100) begin
      @(posedge clock); #1;
      k++;
      if (k == 1) chk({name, ".busy_edge1"}, {63'b0, bus.busy}, {63'b0, e.lat != 1});
      if (k == inj) begin
        bus.DivOp = 1'b1; bus.A = 32'h0; bus.B = 32'h0;
      end else if (k == inj + 1) begin
        bus.DivOp = 1'b0;
      end
      if (bus.done) seen = 1'b1;
    end
    got = sb_q.pop_front();
    if (!seen) begin
      chk({name, ".timeout"}, 64'd0, 64'd1);
    end else begin
      chk({name, ".latency"}, 64'(k), 64'(got.lat));
      chk({name, ".HI"}, {32'b0, bus.HI}, {32'b0, got.hi});
      chk({name, ".LO"}, {32'b0, bus.LO}, {32'b0, got.lo});
      chk({name, ".DivZero"}, {63'b0, bus.DivZero}, {63'b0, got.dz});
      chk({name, ".busy_done"}, {63'b0, bus.busy}, 64'd0);
      $display("op %s m=%0d d=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d",
               name, m, d, a, b, bus.HI, bus.LO, bus.DivZero, k);
      @(posedge clock); #1;
      chk({name, ".done_drop"}, {63'b0, bus.done}, 64'd0);
      chk({name, ".busy_after"}, {63'b0, bus.busy}, 64'd0);
      last_hi = got.hi;
      last_lo = got.lo;
    end
  endtask

  function automatic exp_t fixed(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh; e.lo = el; e.lat = 33; e.dz = 1'b0;
    return e;
  endfunction

  initial begin
    bus.MultOp = 1'b0; bus.DivOp = 1'b0; bus.A = '0; bus.B = '0;

    vecs.push_back('{"mul_7x-3",     1'b1, 1'b0, 32'h7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"div_-7/2",     1'b0, 1'b1, 32'hFFFF_FFF9, 32'h2,        32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"div_7/-2",     1'b0, 1'b1, 32'h7,        32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD});
    vecs.push_back('{"div_min/-1",   1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000});
    vecs.push_back('{"mul_minx-1",   1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000});
    vecs.push_back('{"mul_minxmin",  1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0});
    vecs.push_back('{"both_6,3",     1'b1, 1'b1, 32'h6,        32'h3,        32'h0,         32'h12});
    vecs.push_back('{"div_100/7",    1'b0, 1'b1, 32'h64,       32'h7,        32'h2,         32'hE});
    vecs.push_back('{"div_-100/-7",  1'b0, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hE});
    vecs.push_back('{"mul_-1x-1",    1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        32'h1});
    vecs.push_back('{"mul_maxxmax",  1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1});
`ifndef DIVZERO_DETECT_EN
    vecs.push_back('{"div_5/0",      1'b0, 1'b1, 32'h5,        32'h0,        32'h5,         32'hFFFF_FFFF});
    vecs.push_back('{"div_-5/0",     1'b0, 1'b1, 32'hFFFF_FFFB, 32'h0,        32'hFFFF_FFFB, 32'h1});
`endif
    vecs.push_back('{"div_-100/7",   1'b0, 1'b1, 32'hFFFF_FF9C, 32'h7,        32'hFFFF_FFFE, 32'hFFFF_FFF2});

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst.HI", {32'b0, bus.HI}, 64'd0);
    chk("rst.LO", {32'b0, bus.LO}, 64'd0);
    chk("rst.busy", {63'b0, bus.busy}, 64'd0);
    chk("rst.done", {63'b0, bus.done}, 64'd0);
    chk("rst.DivZero", {63'b0, bus.DivZero}, 64'd0);
    @(negedge clock);
    RESET_in = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b,
             fixed(vecs[i].eh, vecs[i].el), -1);

`ifdef DIVZERO_DETECT_EN
    // Early divide-by-zero: HI/LO must keep the previous result
    begin
      exp_t e;
      e.hi = last_hi; e.lo = last_lo; e.lat = 1; e.dz = 1'b1;
      run_op("divzero_det", 1'b0, 1'b1, 32'h5, 32'h0, e, -1);
    end
`endif

    // DivOp during a multiply is neither honoured nor queued
    run_op("mul_inj_div", 1'b1, 1'b0, 32'h7, 32'hFFFF_FFFD,
           fixed(32'hFFFF_FFFF, 32'hFFFF_FFEB), 10);

    // Reset mid-divide clears results at once
    @(negedge clock);
    bus.DivOp = 1'b1; bus.A = 32'hFFFF_FF9C; bus.B = 32'h7;
    @(posedge clock); #1;
    bus.DivOp = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    RESET_in = 1'b1;
    #1;
    chk("midrst.HI", {32'b0, bus.HI}, 64'd0);
    chk("midrst.LO", {32'b0, bus.LO}, 64'd0);
    chk("midrst.busy", {63'b0, bus.busy}, 64'd0);
    chk("midrst.done", {63'b0, bus.done}, 64'd0);
    last_hi = '0; last_lo = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    RESET_in = 1'b0;
    run_op("post_rst_mul", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000,
           fixed(32'h1, 32'h0), -1);

    for (int i = 0; i < 10; i++) begin
      bit          m;
      logic [31:0] a, b;
      m = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 4 == 3) ? 32'h0 : $urandom;
      if (i == 5) b = 32'hFFFF_FFFF;
      run_op("rnd", m, ~m, a, b, model(m, a, b, last_hi, last_lo), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
